// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
// tmds_encoder : per-channel TMDS 8b/10b encoder, 2-stage pipeline
// Rev 1.0
// ============================================================================
module tmds_encoder #(
  parameter int DISP_W = 6
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic [7:0] video_data,
  input  logic [1:0] ctrl,
  input  logic       video_en,
  output logic [9:0] tmds_out
);

  localparam logic [9:0] c_tok_00 = 10'b1101010100;
  localparam logic [9:0] c_tok_01 = 10'b0010101011;
  localparam logic [9:0] c_tok_10 = 10'b0101010100;
  localparam logic [9:0] c_tok_11 = 10'b1010101011;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Stage 1: transition minimisation
  logic [3:0] n1_w;
  logic       xnor_w;
  logic [8:0] qm_d;
  logic [8:0] qm_q;
  logic       en_q;
  logic [1:0] ctrl_q;

  always_comb begin
    n1_w    = ones8(video_data);
    xnor_w  = (n1_w > 4'd4) || ((n1_w == 4'd4) && !video_data[0]);
    qm_d    = '0;
    qm_d[0] = video_data[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = xnor_w ? ~(qm_d[i-1] ^ video_data[i]) : (qm_d[i-1] ^ video_data[i]);
    end
    qm_d[8] = ~xnor_w;
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      qm_q   <= '0;
      en_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      qm_q   <= qm_d;
      en_q   <= video_en;
      ctrl_q <= ctrl;
    end
  end

  // Stage 2: DC balance
  logic [3:0]               n1q_w;
  logic signed [DISP_W-1:0] n1q_s;
  logic signed [DISP_W-1:0] diff_w;   // N1q - N0q
  logic signed [DISP_W-1:0] two_q8_w;
  logic signed [DISP_W-1:0] two_nq8_w;
  logic signed [DISP_W-1:0] cnt_d;
  logic signed [DISP_W-1:0] cnt_q;
  logic [9:0]               tmds_d;
  logic                     case_a_w;
  logic                     case_b_w;

  always_comb begin
    n1q_w     = ones8(qm_q[7:0]);
    n1q_s     = DISP_W'(n1q_w);
    diff_w    = (n1q_s <<< 1) - $signed(DISP_W'(8));
    two_q8_w  = qm_q[8] ? $signed(DISP_W'(2)) : '0;
    two_nq8_w = qm_q[8] ? '0 : $signed(DISP_W'(2));
    case_a_w  = (cnt_q == '0) || (n1q_w == 4'd4);
    case_b_w  = (!cnt_q[DISP_W-1] && (n1q_w > 4'd4)) ||
                (cnt_q[DISP_W-1] && (n1q_w < 4'd4));
    tmds_d    = c_tok_00;
    cnt_d     = '0;
    if (!en_q) begin
      unique case (ctrl_q)
        2'b00:   tmds_d = c_tok_00;
        2'b01:   tmds_d = c_tok_01;
        2'b10:   tmds_d = c_tok_10;
        default: tmds_d = c_tok_11;
      endcase
    end else if (case_a_w) begin
      tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
      cnt_d  = qm_q[8] ? (cnt_q + diff_w) : (cnt_q - diff_w);
    end else if (case_b_w) begin
      tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      cnt_d  = cnt_q + two_q8_w - diff_w;
    end else begin
      tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
      cnt_d  = cnt_q + diff_w - two_nq8_w;
    end
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      tmds_out <= c_tok_00;
      cnt_q    <= '0;
    end else begin
      tmds_out <= tmds_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder.sv
`default_nettype none
// Testbench for tmds_encoder: random and directed stimulus, scoreboard
// against a running-disparity reference model.
module tb_tmds_encoder;

  logic       pixclk = 1'b0;
  logic       reset;
  logic [7:0] video_data;
  logic [1:0] ctrl;
  logic       video_en;
  logic [9:0] tmds_out;

  tmds_encoder #(.DISP_W(6)) dut (
    .pixclk     (pixclk),
    .reset      (reset),
    .video_data (video_data),
    .ctrl       (ctrl),
    .video_en   (video_en),
    .tmds_out   (tmds_out)
  );

  always #5 pixclk = ~pixclk;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    logic       vid;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_cnt = 0;
  logic v_in = 1'b0;
  logic [1:0] vpipe;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  // Reference: choose the symbol by the balancing rules, then track
  // disparity as the ones-minus-zeros of every emitted video symbol.
  function automatic logic [9:0] model_sym(input logic en, input logic [7:0] d, input logic [1:0] c);
    logic [7:0] qm;
    logic       use_xnor, inv;
    int         ones, zeros;
    logic [9:0] s;
    if (!en) begin
      model_cnt = 0;
      case (c)
        2'b00:   return 10'h354;
        2'b01:   return 10'h0AB;
        2'b10:   return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    use_xnor = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    ones  = $countones(qm);
    zeros = 8 - ones;
    if (model_cnt == 0 || ones == zeros) inv = use_xnor;
    else if ((model_cnt > 0 && ones > zeros) || (model_cnt < 0 && zeros > ones)) inv = 1'b1;
    else inv = 1'b0;
    s = {inv, ~use_xnor, inv ? ~qm : qm};
    model_cnt += 2 * $countones(s) - 10;
    return s;
  endfunction

  // Entered and left at posedge+1.
  task automatic drive(input logic en, input logic [7:0] d, input logic [1:0] c,
                       input logic use_fixed, input logic [9:0] fixed);
    exp_t e;
    video_en   = en;
    video_data = d;
    ctrl       = c;
    e.sym  = model_sym(en, d, c);
    if (use_fixed) e.sym = fixed;
    e.cnt  = model_cnt;
    e.vid  = en;
    e.data = d;
    exp_q.push_back(e);
    v_in = 1'b1;
    @(posedge pixclk);
    #1;
  endtask

  always @(posedge pixclk or posedge reset) begin
    if (reset) vpipe <= 2'b00;
    else       vpipe <= {vpipe[0], v_in};
  end

  always @(negedge pixclk) begin
    exp_t e;
    logic [7:0] x, dec;
    int dcnt;
    if (!reset && vpipe[1]) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        dcnt = int'(dut.cnt_q);
        chk("symbol", int'(tmds_out), int'(e.sym));
        chk("disparity", dcnt, e.cnt);
        chk("disparity_bound", int'(dcnt >= -10 && dcnt <= 10), 1);
        if (e.vid) begin
          x = tmds_out[9] ? ~tmds_out[7:0] : tmds_out[7:0];
          dec[0] = x[0];
          for (int i = 1; i < 8; i++) dec[i] = tmds_out[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
          chk("decode", int'(dec), int'(e.data));
        end
      end
    end
  end

  task automatic mid_reset();
    #2 reset = 1'b1;
    v_in = 1'b0;
    #1;
    chk("async_reset_out", int'(tmds_out), 'h354);
    chk("async_reset_cnt", int'(dut.cnt_q), 0);
    exp_q.delete();
    model_cnt = 0;
    @(posedge pixclk);
    #1 reset = 1'b0;
    drive(1'b1, 8'($urandom), 2'($urandom), 1'b0, 10'h0);
    chk("post_reset_stale", int'(tmds_out), 'h354);
  endtask

  initial begin
    int r;
    reset = 1'b1;
    video_en = 1'b0;
    video_data = 8'h00;
    ctrl = 2'b00;
    #2;
    chk("reset_out", int'(tmds_out), 'h354);
    @(posedge pixclk);
    #1;
    chk("reset_held_out", int'(tmds_out), 'h354);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) drive(1'b0, 8'hA5, 2'b00, 1'b1, 10'h354);
    drive(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
    drive(1'b0, 8'h00, 2'b01, 1'b1, 10'h0AB);
    drive(1'b0, 8'h00, 2'b10, 1'b1, 10'h154);
    drive(1'b0, 8'h00, 2'b11, 1'b1, 10'h2AB);
    drive(1'b1, 8'h00, 2'b11, 1'b1, 10'h100);
    drive(1'b1, 8'h00, 2'b10, 1'b1, 10'h3FF);
    drive(1'b0, 8'hFF, 2'b00, 1'b1, 10'h354);
    drive(1'b1, 8'hFF, 2'b00, 1'b1, 10'h200);
    drive(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
    drive(1'b1, 8'h00, 2'b00, 1'b1, 10'h100);
    drive(1'b0, 8'h00, 2'b01, 1'b1, 10'h0AB);

    for (int i = 0; i < 20000; i++) begin
      if (i == 5000 || i == 12000) mid_reset();
      r = $urandom_range(0, 99);
      drive(r >= 10, 8'($urandom), 2'($urandom), 1'b0, 10'h0);
    end

    v_in = 1'b0;
    video_en = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge pixclk);
    #1;
    chk("drain_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
